// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops, wakes operands from two CDB ports, and issues one ready entry per cycle.
// Optional RS_WAKEUP_BYPASS_EN lets an operand broadcast this cycle count as ready for selection, giving one-cycle wakeup-to-dispatch.
module alu_reservation_station #(
  parameter int RS_SIZE   = 8,
  parameter int ROB_IDX_W = 4,
  parameter int OP_W      = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_in,
  input  logic                 issue_valid,
  input  logic [OP_W-1:0]      issue_op,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic                 issue_qj_busy,
  input  logic                 issue_qk_busy,
  input  logic [ROB_IDX_W-1:0] issue_qj,
  input  logic [ROB_IDX_W-1:0] issue_qk,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  output logic                 full,
  input  logic                 cdb_alu_valid,
  input  logic                 cdb_lsb_valid,
  input  logic [ROB_IDX_W-1:0] cdb_alu_rob_idx,
  input  logic [ROB_IDX_W-1:0] cdb_lsb_rob_idx,
  input  logic [31:0]          cdb_alu_value,
  input  logic [31:0]          cdb_lsb_value,
  output logic                 alu_valid,
  output logic [31:0]          alu_r1,
  output logic [31:0]          alu_r2,
  output logic [ROB_IDX_W-1:0] alu_rob_idx,
  output logic [OP_W-1:0]      alu_op
);
  // Handshake: issue_valid is legal only while full is low and is accepted on that edge;
  // alu_valid is a registered one-cycle issue with no back-pressure other than rdy_in, which freezes producer and consumer together.
  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0]   busy, qj_busy, qk_busy;
  logic [OP_W-1:0]      op_q  [RS_SIZE];
  logic [31:0]          vj_q  [RS_SIZE];
  logic [31:0]          vk_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] qj_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] qk_q  [RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_q [RS_SIZE];

  logic [RS_SIZE-1:0]   wake_j, wake_k, ready;
  logic [31:0]          wake_vj [RS_SIZE];
  logic [31:0]          wake_vk [RS_SIZE];
  logic                 sel_found;
  logic [IDX_W-1:0]     sel_idx, free_idx;
  logic [31:0]          sel_r1, sel_r2;
  logic                 in_j_hit, in_k_hit;

  function automatic logic cdb_hit(input logic [ROB_IDX_W-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_idx == tag) || (cdb_lsb_valid && cdb_lsb_rob_idx == tag);
  endfunction

  // ALU port wins when both broadcasts carry the same tag.
  function automatic logic [31:0] cdb_val(input logic [ROB_IDX_W-1:0] tag);
    return (cdb_alu_valid && cdb_alu_rob_idx == tag) ? cdb_alu_value : cdb_lsb_value;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      wake_j[i]  = busy[i] && qj_busy[i] && cdb_hit(qj_q[i]);
      wake_k[i]  = busy[i] && qk_busy[i] && cdb_hit(qk_q[i]);
      wake_vj[i] = cdb_val(qj_q[i]);
      wake_vk[i] = cdb_val(qk_q[i]);
`ifdef RS_WAKEUP_BYPASS_EN
      ready[i]   = busy[i] && (!qj_busy[i] || wake_j[i]) && (!qk_busy[i] || wake_k[i]);
`else
      ready[i]   = busy[i] && !qj_busy[i] && !qk_busy[i];
`endif
    end
  end

  // Descending scan leaves the lowest qualifying index in each result.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
      if (!busy[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_r1 = vj_q[sel_idx];
    sel_r2 = vk_q[sel_idx];
`ifdef RS_WAKEUP_BYPASS_EN
    if (wake_j[sel_idx]) sel_r1 = wake_vj[sel_idx];
    if (wake_k[sel_idx]) sel_r2 = wake_vk[sel_idx];
`endif
  end

  assign full     = &busy;
  assign in_j_hit = issue_qj_busy && cdb_hit(issue_qj);
  assign in_k_hit = issue_qk_busy && cdb_hit(issue_qk);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy        <= '0;
      qj_busy     <= '0;
      qk_busy     <= '0;
      alu_valid   <= 1'b0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      alu_rob_idx <= '0;
      alu_op      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        rob_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear_in) begin
        busy      <= '0;
        alu_valid <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (wake_j[i]) begin
            vj_q[i]    <= wake_vj[i];
            qj_busy[i] <= 1'b0;
          end
          if (wake_k[i]) begin
            vk_q[i]    <= wake_vk[i];
            qk_busy[i] <= 1'b0;
          end
        end
        alu_valid <= sel_found;
        if (sel_found) begin
          busy[sel_idx] <= 1'b0;
          alu_r1        <= sel_r1;
          alu_r2        <= sel_r2;
          alu_rob_idx   <= rob_q[sel_idx];
          alu_op        <= op_q[sel_idx];
        end
        // The free slot was idle before this edge, so it never collides with wakeup or dispatch.
        if (issue_valid && !full) begin
          busy[free_idx]    <= 1'b1;
          op_q[free_idx]    <= issue_op;
          rob_q[free_idx]   <= issue_rob_idx;
          qj_q[free_idx]    <= issue_qj;
          qk_q[free_idx]    <= issue_qk;
          vj_q[free_idx]    <= in_j_hit ? cdb_val(issue_qj) : issue_vj;
          vk_q[free_idx]    <= in_k_hit ? cdb_val(issue_qk) : issue_vk;
          qj_busy[free_idx] <= issue_qj_busy && !in_j_hit;
          qk_busy[free_idx] <= issue_qk_busy && !in_k_hit;
        end
      end
    end
  end

  always @(posedge clk_in) begin
    if (rst_in && rdy_in && !clear_in && issue_valid)
      assert (!full) else $warning("issue_valid while reservation station full; op dropped");
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Randomized and directed bench for alu_reservation_station against a cycle-level behavioural model.
// Honours RS_WAKEUP_BYPASS_EN when the same define is given to the build.
module tb_alu_reservation_station;
  localparam int RS = 8;
  localparam int RW = 4;
  localparam int OW = 6;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear_in, issue_valid;
  logic [OW-1:0] issue_op;
  logic [31:0]   issue_vj, issue_vk;
  logic          issue_qj_busy, issue_qk_busy;
  logic [RW-1:0] issue_qj, issue_qk, issue_rob_idx;
  logic          full;
  logic          cdb_alu_valid, cdb_lsb_valid;
  logic [RW-1:0] cdb_alu_rob_idx, cdb_lsb_rob_idx;
  logic [31:0]   cdb_alu_value, cdb_lsb_value;
  logic          alu_valid;
  logic [31:0]   alu_r1, alu_r2;
  logic [RW-1:0] alu_rob_idx;
  logic [OW-1:0] alu_op;

  // clock / reset
  always #5 clk_in = ~clk_in;

  alu_reservation_station #(.RS_SIZE(RS), .ROB_IDX_W(RW), .OP_W(OW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_busy(issue_qj_busy), .issue_qk_busy(issue_qk_busy),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rob_idx(issue_rob_idx),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_rob_idx(cdb_alu_rob_idx), .cdb_lsb_rob_idx(cdb_lsb_rob_idx),
    .cdb_alu_value(cdb_alu_value), .cdb_lsb_value(cdb_lsb_value),
    .alu_valid(alu_valid), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_rob_idx(alu_rob_idx), .alu_op(alu_op)
  );

  // behavioural model: an unordered pool of pending ops, lowest slot wins
  typedef struct {
    bit            busy;
    logic [OW-1:0] op;
    logic [31:0]   vj, vk;
    bit            jw, kw;
    logic [RW-1:0] qj, qk, rob;
  } ent_t;

  ent_t        m [RS];
  bit          exp_valid;
  bit          m_disp;
  logic [73:0] exp_pay;
  logic [73:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int c = 0;
    foreach (m[i]) if (m[i].busy) c++;
    return c;
  endfunction

  function automatic bit bus_hit(input logic [RW-1:0] t, output logic [31:0] v);
    if (cdb_alu_valid && cdb_alu_rob_idx == t) begin v = cdb_alu_value; return 1'b1; end
    if (cdb_lsb_valid && cdb_lsb_rob_idx == t) begin v = cdb_lsb_value; return 1'b1; end
    v = '0;
    return 1'b0;
  endfunction

  task automatic model_reset();
    foreach (m[i]) m[i] = '{default: '0};
    exp_valid = 1'b0;
    exp_pay   = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int pick, slot;
    logic [31:0] v, r1, r2;
    bit hj, hk;
    m_disp = 1'b0;
    if (!rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    if (clear_in) begin
      foreach (m[i]) m[i].busy = 1'b0;
      exp_valid = 1'b0;
      return;
    end
    pick = -1;
    slot = -1;
    for (int i = 0; i < RS; i++) begin
      if (slot < 0 && !m[i].busy) slot = i;
      if (pick < 0 && m[i].busy) begin
        r1 = m[i].vj; r2 = m[i].vk; hj = !m[i].jw; hk = !m[i].kw;
        if (BYP && m[i].jw && bus_hit(m[i].qj, v)) begin hj = 1'b1; r1 = v; end
        if (BYP && m[i].kw && bus_hit(m[i].qk, v)) begin hk = 1'b1; r2 = v; end
        if (hj && hk) begin pick = i; exp_pay = {r1, r2, m[i].rob, m[i].op}; end
      end
    end
    exp_valid = (pick >= 0);
    if (pick >= 0) begin m_disp = 1'b1; exp_q.push_back(exp_pay); end
    foreach (m[i]) if (m[i].busy) begin
      if (m[i].jw && bus_hit(m[i].qj, v)) begin m[i].vj = v; m[i].jw = 1'b0; end
      if (m[i].kw && bus_hit(m[i].qk, v)) begin m[i].vk = v; m[i].kw = 1'b0; end
    end
    if (pick >= 0) m[pick].busy = 1'b0;
    if (issue_valid && slot >= 0) begin
      m[slot].busy = 1'b1;
      m[slot].op   = issue_op;
      m[slot].rob  = issue_rob_idx;
      m[slot].qj   = issue_qj;
      m[slot].qk   = issue_qk;
      m[slot].jw   = issue_qj_busy;
      m[slot].kw   = issue_qk_busy;
      m[slot].vj   = issue_vj;
      m[slot].vk   = issue_vk;
      if (issue_qj_busy && bus_hit(issue_qj, v)) begin m[slot].jw = 1'b0; m[slot].vj = v; end
      if (issue_qk_busy && bus_hit(issue_qk, v)) begin m[slot].kw = 1'b0; m[slot].vk = v; end
    end
  endtask

  // driver tasks
  task automatic idle();
    rdy_in = 1'b1; clear_in = 1'b0; issue_valid = 1'b0; issue_op = '0;
    issue_vj = '0; issue_vk = '0; issue_qj_busy = 1'b0; issue_qk_busy = 1'b0;
    issue_qj = '0; issue_qk = '0; issue_rob_idx = '0;
    cdb_alu_valid = 1'b0; cdb_lsb_valid = 1'b0; cdb_alu_rob_idx = '0; cdb_lsb_rob_idx = '0;
    cdb_alu_value = '0; cdb_lsb_value = '0;
  endtask

  task automatic put(input logic [OW-1:0] op, input logic [31:0] vj, input logic [31:0] vk,
                     input bit jb, input logic [RW-1:0] qj, input bit kb, input logic [RW-1:0] qk,
                     input logic [RW-1:0] rob);
    issue_valid = 1'b1; issue_op = op; issue_vj = vj; issue_vk = vk;
    issue_qj_busy = jb; issue_qj = qj; issue_qk_busy = kb; issue_qk = qk; issue_rob_idx = rob;
  endtask

  task automatic cdb_a(input logic [RW-1:0] t, input logic [31:0] v);
    cdb_alu_valid = 1'b1; cdb_alu_rob_idx = t; cdb_alu_value = v;
  endtask

  task automatic cdb_l(input logic [RW-1:0] t, input logic [31:0] v);
    cdb_lsb_valid = 1'b1; cdb_lsb_rob_idx = t; cdb_lsb_value = v;
  endtask

  // scoreboard: one clock with model prediction and comparison
  task automatic step();
    logic [73:0] want;
    check("full", 128'(full), 128'(occupancy() == RS));
    model_step();
    @(posedge clk_in);
    #1;
    check("alu_valid", 128'(alu_valid), 128'(exp_valid));
    if (m_disp) begin
      want = exp_q.pop_front();
      check("alu_dispatch", 128'({alu_r1, alu_r2, alu_rob_idx, alu_op}), 128'(want));
    end else begin
      check("alu_hold", 128'({alu_r1, alu_r2, alu_rob_idx, alu_op}), 128'(exp_pay));
    end
  endtask

  task automatic wait_dispatch(input int budget, output int lat);
    lat = 0;
    do begin
      step();
      idle();
      lat++;
    end while (!alu_valid && lat < budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    idle();
    rst_in = 1'b1;
    model_reset();
    #2 rst_in = 1'b0;
    repeat (2) step();
    check("rst_valid", 128'(alu_valid), 128'd0);
    check("rst_r1", 128'(alu_r1), 128'd0);
    check("rst_r2", 128'(alu_r2), 128'd0);
    check("rst_rob", 128'(alu_rob_idx), 128'd0);
    check("rst_op", 128'(alu_op), 128'd0);
    check("rst_full", 128'(full), 128'd0);
    rst_in = 1'b1;
    step();

    // ready ADD: one cycle allocate-to-dispatch, then idle
    put(6'b010000, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
    step(); idle();
    step();
    check("add_valid", 128'(alu_valid), 128'd1);
    check("add_r1", 128'(alu_r1), 128'd5);
    check("add_r2", 128'(alu_r2), 128'd7);
    check("add_op", 128'(alu_op), 128'b010000);
    step();
    check("add_done", 128'(alu_valid), 128'd0);

    // SUB waiting on tag 3; wrong tag wakes nothing
    put(6'b010001, 32'd0, 32'd9, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2);
    step(); idle();
    cdb_l(4'd4, 32'd55);
    step(); idle();
    check("wrong_tag", 128'(alu_valid), 128'd0);
    cdb_l(4'd3, 32'd100);
    wait_dispatch(5, lat);
    check("wake_lat", 128'(lat), BYP ? 128'd1 : 128'd2);
    check("wake_r1", 128'(alu_r1), 128'd100);
    check("wake_r2", 128'(alu_r2), 128'd9);
    step();

    // fill all entries on tag 2, overflow issue dropped, drain in index order
    for (int i = 0; i < RS; i++) begin
      put(6'b010010, 32'd0, 32'(i + 1), 1'b1, 4'd2, 1'b0, 4'd0, RW'(i));
      step(); idle();
    end
    check("full_set", 128'(full), 128'd1);
    put(6'b010010, 32'd0, 32'd99, 1'b1, 4'd2, 1'b0, 4'd0, 4'd8);
    step(); idle();
    check("full_still", 128'(full), 128'd1);
    cdb_a(4'd2, 32'h55);
    wait_dispatch(5, lat);
    check("fill_lat", 128'(lat), BYP ? 128'd1 : 128'd2);
    for (int i = 0; i < RS; i++) begin
      check("drain_valid", 128'(alu_valid), 128'd1);
      check("drain_rob", 128'(alu_rob_idx), 128'(i));
      check("drain_r1", 128'(alu_r1), 128'h55);
      step();
    end
    check("drain_end", 128'(alu_valid), 128'd0);
    check("drain_full", 128'(full), 128'd0);

    // issue-time capture with both CDBs matching: ALU port wins
    put(6'b010011, 32'd1, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
    cdb_a(4'd6, 32'd11);
    cdb_l(4'd6, 32'd22);
    step(); idle();
    step();
    check("dual_valid", 128'(alu_valid), 128'd1);
    check("dual_r2", 128'(alu_r2), 128'd11);
    check("dual_rob", 128'(alu_rob_idx), 128'd5);
    step();

    // flush with entries queued and a coincident issue
    put(6'b010000, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd11);
    step(); idle();
    put(6'b010000, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12);
    step(); idle();
    check("pre_clear_rob", 128'(alu_rob_idx), 128'd11);
    put(6'b010000, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
    clear_in = 1'b1;
    step(); idle();
    check("clear_valid", 128'(alu_valid), 128'd0);
    check("clear_full", 128'(full), 128'd0);
    repeat (2) begin
      step();
      check("clear_quiet", 128'(alu_valid), 128'd0);
    end

    // freeze with valid output and a pending broadcast, then resume
    put(6'b010100, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd10);
    step(); idle();
    put(6'b010101, 32'd0, 32'd8, 1'b1, 4'd5, 1'b0, 4'd0, 4'd14);
    step(); idle();
    repeat (3) begin
      rdy_in = 1'b0;
      cdb_a(4'd5, 32'd77);
      step(); idle();
      check("frz_valid", 128'(alu_valid), 128'd1);
      check("frz_rob", 128'(alu_rob_idx), 128'd10);
    end
    cdb_a(4'd5, 32'd77);
    wait_dispatch(5, lat);
    check("resume_lat", 128'(lat), BYP ? 128'd1 : 128'd2);
    check("resume_rob", 128'(alu_rob_idx), 128'd14);
    check("resume_r1", 128'(alu_r1), 128'd77);
    step();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy_in   = ($urandom_range(0, 9) != 0);
      clear_in = ($urandom_range(0, 39) == 0);
      if (occupancy() < RS && $urandom_range(0, 2) != 0)
        put(OW'($urandom_range(16, 55)), $urandom, $urandom,
            1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), RW'($urandom_range(0, 7)), RW'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) cdb_a(RW'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) cdb_l(RW'($urandom_range(0, 7)), $urandom);
      step();
    end
    idle();

    // asynchronous reset mid-stream
    put(6'b010110, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
    step(); idle();
    put(6'b010111, 32'd6, 32'd7, 1'b1, 4'd1, 1'b0, 4'd0, 4'd3);
    step(); idle();
    #2 rst_in = 1'b0;
    #1;
    check("arst_valid", 128'(alu_valid), 128'd0);
    check("arst_r1", 128'(alu_r1), 128'd0);
    check("arst_r2", 128'(alu_r2), 128'd0);
    check("arst_rob", 128'(alu_rob_idx), 128'd0);
    check("arst_op", 128'(alu_op), 128'd0);
    check("arst_full", 128'(full), 128'd0);
    model_reset();
    step();
    rst_in = 1'b1;
    cdb_a(4'd1, 32'd1);
    step(); idle();
    step();
    check("post_rst_idle", 128'(alu_valid), 128'd0);
    check("sb_empty", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_reservation_station.md
# alu_reservation_station

Reservation station that sits directly upstream of the ALU in the out-of-order core. Holds up to `RS_SIZE` dispatched arithmetic/branch micro-ops, wakes pending operands from two common-data-bus (CDB) broadcast ports, and issues one operand-ready entry per cycle to the ALU as registered `valid`/`r1`/`r2`/`rob_idx`/`rs_op_type`. A misprediction clear empties it in one cycle.

## Interface
- `RS_SIZE`, 8: number of entries (power of two, 2..16)
- `ROB_IDX_W`, 4: ROB index width
- `OP_W`, 6: op-type width (`01yxxx` arith, `110xxx` branch)
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset, asynchronous, active-low
- `rdy_in`  in  1  global ready; low freezes all state and outputs
- `clear_in`  in  1  synchronous flush (misprediction)
- `issue_valid`  in  1  dispatcher presents a new entry
- `issue_op`  in  OP_W  op type
- `issue_vj`, `issue_vk`  in  32 each  operand values (vk = immediate for I-type)
- `issue_qj_busy`, `issue_qk_busy`  in  1 each  operand still pending
- `issue_qj`, `issue_qk`  in  ROB_IDX_W each  producer ROB tag when busy
- `issue_rob_idx`  in  ROB_IDX_W  destination ROB index
- `full`  out  1  no free entry (combinational from current occupancy)
- `cdb_alu_valid`, `cdb_lsb_valid`  in  1 each  broadcast valid
- `cdb_alu_rob_idx`, `cdb_lsb_rob_idx`  in  ROB_IDX_W each  broadcast tag
- `cdb_alu_value`, `cdb_lsb_value`  in  32 each  broadcast value
- `alu_valid`  out  1  issue to ALU (registered)
- `alu_r1`, `alu_r2`  out  32 each  operands (registered)
- `alu_rob_idx`  out  ROB_IDX_W  (registered)
- `alu_op`  out  OP_W  (registered)

## Operation
- Entry fields: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, rob_idx.
- Allocate: `issue_valid && !full` writes the lowest-index free entry. `issue_valid` while `full` is a protocol violation; the op is dropped (sim assertion fires).
- Issue-time capture: if an incoming pending operand's tag equals a valid CDB tag that same cycle, the CDB value is stored and the operand marked ready. If both CDBs match, ALU port wins.
- Wakeup: every busy entry compares qj/qk against both CDBs each cycle; on match, value latched, busy flag cleared.
- Select: lowest-index busy entry with both operands ready. Selected entry is freed on the same edge its operands are driven to `alu_*`; `alu_valid<=1`. No ready entry -> `alu_valid<=0`, other `alu_*` hold.
- Allocation and dispatch in the same cycle are allowed; `full` reflects pre-edge occupancy, so a full RS does not accept even while dispatching.
- Priority: `rst_in` low > `!rdy_in` (hold everything) > `clear_in` (all entries freed, `alu_valid<=0`) > normal.

## Timing
- Reset (async, `rst_in` low): all entries free, `alu_valid=0`, `alu_r1=0`, `alu_r2=0`, `alu_rob_idx=0`, `alu_op=0`; `full=0`.
- Allocate-to-dispatch latency with operands ready at issue: 1 cycle (write at edge N, `alu_valid` high after edge N+1).
- CDB wakeup at cycle N: `alu_valid` for that entry after edge N+1 with bypass enabled, N+2 without (see Configuration).
- `rdy_in` low holds `alu_valid` high if it was high; ALU consumes it exactly once at the next edge with `rdy_in` high, since both blocks freeze together.
- `clear_in` coincident with `issue_valid`: the new entry is not allocated.

## Configuration
- `RS_WAKEUP_BYPASS_EN` defined: select logic treats an operand matched by a CDB this cycle as ready and muxes the CDB value straight into `alu_r1`/`alu_r2`; wakeup-to-dispatch is 1 cycle.
- Undefined: select only sees operands already latched in the entry; wakeup-to-dispatch is 2 cycles. Shorter combinational path. Issue-time capture is present in both builds.

## Test plan
- Reset then issue ADD (op `010000`, vj=5, vk=7, no pending) -> after next edge `alu_valid=1`, `alu_r1=5`, `alu_r2=7`, `alu_op=010000`; one cycle later `alu_valid=0`.
- Issue SUB with qj busy tag 3; broadcast `cdb_lsb` tag 3 value 100 -> `alu_r1=100` at wakeup+1 (bypass) or wakeup+2 (no bypass); a broadcast with tag 4 causes no dispatch.
- Issue 8 entries all pending on tag 2 -> `full=1`, 9th issue dropped; broadcast tag 2 on `cdb_alu` -> entries dispatch in index order 0..7 over 8 consecutive cycles.
- Issue with qk tag 6 in the same cycle `cdb_alu` and `cdb_lsb` both broadcast tag 6 (values 11 and 22) -> entry dispatches with `alu_r2=11`.
- Two ready entries queued, assert `clear_in` -> `alu_valid=0` next edge, `full=0`, no further dispatches.
- Hold `rdy_in` low 3 cycles with `alu_valid=1` and a CDB broadcast pending -> outputs and entries unchanged; resume -> dispatch continues with no lost or duplicated op; pull `rst_in` low mid-stream -> outputs zero immediately without a clock edge.
